muldiv_issue_ctrl: RTL and testbench
====================================

Name: muldiv_issue_ctrl

Overview:
Core-side initiator for the multi-cycle multiplier/divider.
- Accepts a MULT/DIV request from decode and registers the operands.
- Pulses ctrl_MULT/ctrl_DIV, then holds operands stable until the unit raises data_resultRDY.
- Returns the result, or an exception code, as a single-cycle register-file writeback.
- Drives stall/busy outputs for the pipeline hazard logic.
- Sits between decode/execute and the mul/div unit.

Parameters:
MIN_WAIT, 2, cycles after the ctrl pulse during which data_resultRDY is ignored (the unit's RDY is stale right after issue)
TIMEOUT_CYCLES, 48, WAIT/DRAIN cycles before abandoning the op
EXC_REG, 30, destination register for exception status
MULT_EXC_CODE, 4, status value written on a multiply exception
DIV_EXC_CODE, 5, status value written on a divide exception

Ports:
clock  in  1  single system clock, all state updates on rising edge
clrn  in  1  synchronous active-low reset
issue_valid  in  1  decode presents a mult/div op
issue_is_div  in  1  1=DIV, 0=MULT
issue_rd  in  5  destination register
issue_opA  in  32  multiplicand / dividend
issue_opB  in  32  multiplier / divisor
flush  in  1  cancel the in-flight op (branch mispredict/exception)
issue_ready  out  1  request accepted this cycle when high with issue_valid
stall  out  1  high whenever state != IDLE
busy_rd  out  5  rd of in-flight op, 0 when idle
data_operandA  out  32  to unit, registered
data_operandB  out  32  to unit, registered
ctrl_MULT  out  1  one-cycle issue pulse
ctrl_DIV  out  1  one-cycle issue pulse
data_result  in  32  from unit
data_exception  in  1  from unit
data_resultRDY  in  1  from unit
wb_valid  out  1  one-cycle register-file write strobe
wb_rd  out  5  write address
wb_data  out  32  write data
timeout_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (clrn=0 at a rising edge, any state):
  - state=IDLE.
  - All outputs 0 except issue_ready=1.
  - Operand regs 0, counter 0.
  - An op in flight is abandoned; the unit is not informed.
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- IDLE:
  - issue_ready=1.
  - On issue_valid & ~flush: latch opA/opB/rd/is_div, go ISSUE.
  - flush takes priority over a concurrent issue_valid; the request is not accepted.
- ISSUE (exactly 1 cycle):
  - ctrl_DIV=is_div, ctrl_MULT=~is_div. Never both high.
  - data_operandA/B already valid this cycle.
  - Counter cleared.
  - Next state WAIT, or DRAIN if flush.
- WAIT:
  - Counter increments each cycle.
  - data_resultRDY is sampled only when counter >= MIN_WAIT.
  - When sampled high, capture data_result/data_exception, go WB.
  - flush -> DRAIN, keeping the counter.
  - counter == TIMEOUT_CYCLES with no RDY -> pulse timeout_err, go IDLE, no writeback.
  - RDY and flush in the same cycle: flush wins; result discarded, go IDLE directly.
- WB (exactly 1 cycle):
  - wb_valid=1.
  - No exception: wb_rd=latched rd, wb_data=captured result.
  - Exception: wb_rd=EXC_REG, wb_data=DIV_EXC_CODE if is_div else MULT_EXC_CODE.
  - Writes to rd=0 still strobe wb_valid; the register file ignores r0.
  - flush during WB has no effect; the write is committed.
  - Next state IDLE.
- DRAIN:
  - Wait for a sampled data_resultRDY (same MIN_WAIT rule), then IDLE with no writeback.
  - Same timeout rule as WAIT.
  - Required so that a new issue never overlaps an unfinished unit op.
- Register/output rules:
  - data_operandA/B hold their values from ISSUE through WB/DRAIN exit; they are unchanged in IDLE.
  - busy_rd = latched rd in ISSUE/WAIT/WB, 0 in DRAIN and IDLE.
  - Counter is 6 bits, saturating; it must cover TIMEOUT_CYCLES.
- Latency and throughput:
  - Accept edge -> ctrl pulse: 1 cycle.
  - RDY sample -> wb_valid: 1 cycle.
  - Back-to-back throughput: one op per (unit latency + 3) cycles; IDLE lasts at least one cycle between ops.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/ISSUE/WAIT/WB/DRAIN)
  - EXC_REG, MULT_EXC_CODE, DIV_EXC_CODE
  - the 5-bit register-address width
- Natural sub-module: muldiv_wait_counter. It contains the counter, the MIN_WAIT qualify, and the timeout compare, and outputs rdy_qualified and timed_out.

Test Plan:
- MULT 6*7, rd=5, unit model RDY after 34 cycles -> ctrl_MULT high exactly 1 cycle; stall high throughout; single wb_valid with rd=5, data=42; issue_ready back 1 cycle after WB.
- DIV -100/7, rd=9 -> wb rd=9, data=-14 (0xFFFFFFF2); ctrl_DIV pulsed once; ctrl_MULT never high.
- DIV 5/0 with data_exception=1 at RDY -> wb rd=30, data=5; no write to the original rd.
- Flush 10 cycles into WAIT -> DRAIN; no wb_valid; issue_ready stays 0 until the cycle after the qualified RDY; a queued issue_valid is then accepted.
- Stale RDY held high at issue -> ignored for MIN_WAIT cycles; no wb before cycle 2. Unit never asserts RDY -> timeout_err pulse at counter=48, then IDLE.
- clrn low mid-WAIT, plus RDY and flush colliding in the same cycle -> all outputs at reset values next cycle; collision yields IDLE with no wb_valid.

Source files
------------

// File: rtl/muldiv_issue_ctrl_pkg.sv
// muldiv_issue_ctrl_pkg: shared state encoding, register width and exception constants
package muldiv_issue_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] EXC_REG = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE = 32'd5;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DRAIN} state_t;
endpackage

// File: rtl/muldiv_wait_counter.sv
// muldiv_wait_counter: saturating wait counter with stale-ready masking and timeout compare
module muldiv_wait_counter #(
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic clock,
  input  logic clrn,
  input  logic clear,
  input  logic en,
  input  logic rdy,
  output logic rdy_qualified,
  output logic timed_out
);
  logic [5:0] cnt;
  always_ff @(posedge clock)
    if (!clrn || clear) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 6'd1;
  assign rdy_qualified = rdy && cnt >= 6'(MIN_WAIT);
  assign timed_out = cnt == 6'(TIMEOUT_CYCLES);
endmodule

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: issues mult/div ops to the unit, waits for the result and writes it back
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic             issue_valid,
  input  logic             issue_is_div,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [31:0]      issue_opA,
  input  logic [31:0]      issue_opB,
  input  logic             flush,
  output logic             issue_ready,
  output logic             stall,
  output logic [REG_W-1:0] busy_rd,
  output logic [31:0]      data_operandA,
  output logic [31:0]      data_operandB,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  input  logic [31:0]      data_result,
  input  logic             data_exception,
  input  logic             data_resultRDY,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  output logic             timeout_err
);
  state_t state, next;
  logic is_div, exc, rdy_q, timed_out, accept, capture;
  logic [REG_W-1:0] rd;
  logic [31:0] result;
  muldiv_wait_counter #(.MIN_WAIT(MIN_WAIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cnt (
    .clock,
    .clrn,
    .clear(state == IDLE || state == ISSUE),
    .en(state == WAIT || state == DRAIN),
    .rdy(data_resultRDY),
    .rdy_qualified(rdy_q),
    .timed_out
  );
  always_ff @(posedge clock)
    if (!clrn) begin
      state <= IDLE;
      rd <= '0;
      is_div <= 1'b0;
      exc <= 1'b0;
      result <= '0;
      data_operandA <= '0;
      data_operandB <= '0;
    end else begin
      state <= next;
      if (accept) begin
        rd <= issue_rd;
        is_div <= issue_is_div;
        data_operandA <= issue_opA;
        data_operandB <= issue_opB;
      end
      if (capture) begin
        result <= data_result;
        exc <= data_exception;
      end
    end
  // a flush colliding with a qualified ready drops the result and returns straight to IDLE
  always_comb begin
    next = state;
    accept = 1'b0;
    capture = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        accept = issue_valid && !flush;
        next = accept ? ISSUE : IDLE;
      end
      ISSUE: next = flush ? DRAIN : WAIT;
      WAIT: begin
        if (rdy_q) begin
          capture = !flush;
          next = flush ? IDLE : WB;
        end else if (timed_out) begin
          timeout_err = 1'b1;
          next = IDLE;
        end else if (flush) next = DRAIN;
      end
      WB: next = IDLE;
      DRAIN: begin
        if (rdy_q) next = IDLE;
        else if (timed_out) begin
          timeout_err = 1'b1;
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end
  assign issue_ready = state == IDLE;
  assign stall = state != IDLE;
  assign busy_rd = (state == ISSUE || state == WAIT || state == WB) ? rd : '0;
  assign ctrl_MULT = state == ISSUE && !is_div;
  assign ctrl_DIV = state == ISSUE && is_div;
  assign wb_valid = state == WB;
  assign wb_rd = !wb_valid ? '0 : exc ? EXC_REG : rd;
  assign wb_data = !wb_valid ? '0 : exc ? (is_div ? DIV_EXC_CODE : MULT_EXC_CODE) : result;
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb_muldiv_issue_ctrl: directed checks of issue, wait, writeback, drain, timeout and reset
module tb_muldiv_issue_ctrl;
  logic clock = 1'b0;
  logic clrn, issue_valid, issue_is_div, flush, data_exception, data_resultRDY;
  logic [4:0] issue_rd, busy_rd, wb_rd;
  logic [31:0] issue_opA, issue_opB, data_result, data_operandA, data_operandB, wb_data;
  logic issue_ready, stall, ctrl_MULT, ctrl_DIV, wb_valid, timeout_err;
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  muldiv_issue_ctrl dut (
    .clock(clock), .clrn(clrn), .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_rd(issue_rd), .issue_opA(issue_opA), .issue_opB(issue_opB), .flush(flush),
    .issue_ready(issue_ready), .stall(stall), .busy_rd(busy_rd),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .data_result(data_result),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .timeout_err(timeout_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic div, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    issue_valid = 1'b1;
    issue_is_div = div;
    issue_rd = rd;
    issue_opA = a;
    issue_opB = b;
    #1;
    @(negedge clock);
    issue_valid = 1'b0;
    #1;
  endtask
  task automatic quiet(input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      #1;
      if (ctrl_MULT || ctrl_DIV || wb_valid || timeout_err || !stall || issue_ready) bad++;
    end
    chk(tag, 32'(bad), 0);
  endtask
  task automatic step();
    @(negedge clock);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(issue_ready), 1);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_busy_rd"}, 32'(busy_rd), 0);
    chk({tag, "_opA"}, data_operandA, 0);
    chk({tag, "_opB"}, data_operandB, 0);
    chk({tag, "_ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 0);
    chk({tag, "_wb"}, 32'({wb_valid, timeout_err}), 0);
  endtask
  initial begin
    clrn = 1'b0; issue_valid = 1'b0; issue_is_div = 1'b0; issue_rd = '0;
    issue_opA = '0; issue_opB = '0; flush = 1'b0; data_result = '0;
    data_exception = 1'b0; data_resultRDY = 1'b0;
    repeat (2) step();
    #1;
    reset_vals("rst");
    step(); clrn = 1'b1;
    // MULT 6*7 -> rd 5, RDY in the 34th cycle after the ctrl pulse
    issue(1'b0, 5'd5, 32'd6, 32'd7);
    chk("mul_ctrl_MULT", 32'(ctrl_MULT), 1);
    chk("mul_ctrl_DIV", 32'(ctrl_DIV), 0);
    chk("mul_opA", data_operandA, 6);
    chk("mul_opB", data_operandB, 7);
    chk("mul_busy_rd", 32'(busy_rd), 5);
    chk("mul_ready", 32'(issue_ready), 0);
    quiet(33, "mul_wait_quiet");
    step(); data_resultRDY = 1'b1; data_result = 32'd42; #1;
    chk("mul_rdy_no_wb", 32'(wb_valid), 0);
    step(); data_resultRDY = 1'b0; data_result = '0; #1;
    chk("mul_wb_valid", 32'(wb_valid), 1);
    chk("mul_wb_rd", 32'(wb_rd), 5);
    chk("mul_wb_data", wb_data, 42);
    step(); #1;
    chk("mul_idle_ready", 32'(issue_ready), 1);
    chk("mul_idle_wb", 32'(wb_valid), 0);
    chk("mul_idle_busy", 32'(busy_rd), 0);
    chk("mul_idle_opA_held", data_operandA, 6);
    // DIV -100/7 -> rd 9, flush during WB is ignored
    issue(1'b1, 5'd9, 32'hFFFFFF9C, 32'd7);
    chk("div_ctrl_DIV", 32'(ctrl_DIV), 1);
    chk("div_ctrl_MULT", 32'(ctrl_MULT), 0);
    quiet(5, "div_wait_quiet");
    step(); data_resultRDY = 1'b1; data_result = 32'hFFFFFFF2; #1;
    step(); data_resultRDY = 1'b0; flush = 1'b1; #1;
    chk("div_wb_valid", 32'(wb_valid), 1);
    chk("div_wb_rd", 32'(wb_rd), 9);
    chk("div_wb_data", wb_data, 32'hFFFFFFF2);
    step(); flush = 1'b0; #1;
    chk("div_idle_stall", 32'(stall), 0);
    chk("div_idle_wb", 32'(wb_valid), 0);
    // DIV 5/0 with exception -> status to r30
    issue(1'b1, 5'd12, 32'd5, 32'd0);
    quiet(3, "exc_wait_quiet");
    step(); data_resultRDY = 1'b1; data_exception = 1'b1; data_result = 32'h1234; #1;
    step(); data_resultRDY = 1'b0; data_exception = 1'b0; #1;
    chk("exc_wb_valid", 32'(wb_valid), 1);
    chk("exc_wb_rd", 32'(wb_rd), 30);
    chk("exc_wb_data", wb_data, 5);
    step(); #1;
    chk("exc_idle_ready", 32'(issue_ready), 1);
    // flush beats a concurrent issue in IDLE
    step(); issue_valid = 1'b1; flush = 1'b1; issue_rd = 5'd1; #1;
    chk("flush_idle_ready", 32'(issue_ready), 1);
    step(); issue_valid = 1'b0; flush = 1'b0; #1;
    chk("flush_idle_stall", 32'(stall), 0);
    chk("flush_idle_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 0);
    // flush 10 cycles into WAIT, drain, then accept a queued issue
    issue(1'b0, 5'd7, 32'd3, 32'd4);
    quiet(10, "drain_wait_quiet");
    step(); flush = 1'b1; #1;
    chk("drain_pre_busy", 32'(busy_rd), 7);
    step(); flush = 1'b0; issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd3;
    issue_opA = 32'd1; issue_opB = 32'd2; #1;
    chk("drain_busy_rd", 32'(busy_rd), 0);
    chk("drain_stall", 32'(stall), 1);
    chk("drain_ready", 32'(issue_ready), 0);
    begin
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
        step(); #1;
        if (issue_ready || wb_valid || ctrl_MULT || ctrl_DIV) bad++;
      end
      chk("drain_hold", 32'(bad), 0);
    end
    step(); data_resultRDY = 1'b1; #1;
    chk("drain_rdy_ready", 32'(issue_ready), 0);
    step(); data_resultRDY = 1'b0; #1;
    chk("drain_exit_ready", 32'(issue_ready), 1);
    chk("drain_exit_wb", 32'(wb_valid), 0);
    step(); issue_valid = 1'b0; #1;
    chk("queued_ctrl_MULT", 32'(ctrl_MULT), 1);
    chk("queued_busy_rd", 32'(busy_rd), 3);
    chk("queued_opA", data_operandA, 1);
    quiet(2, "queued_wait_quiet");
    step(); data_resultRDY = 1'b1; data_result = 32'd2; #1;
    step(); data_resultRDY = 1'b0; #1;
    chk("queued_wb_valid", 32'(wb_valid), 1);
    chk("queued_wb_rd", 32'(wb_rd), 3);
    chk("queued_wb_data", wb_data, 2);
    // stale RDY held high from before issue
    step(); data_resultRDY = 1'b1; data_result = 32'd99; #1;
    issue(1'b0, 5'd4, 32'd8, 32'd8);
    chk("stale_issue_wb", 32'(wb_valid), 0);
    quiet(2, "stale_masked");
    step(); #1;
    chk("stale_cnt2_wb", 32'(wb_valid), 0);
    step(); data_resultRDY = 1'b0; #1;
    chk("stale_wb_valid", 32'(wb_valid), 1);
    chk("stale_wb_data", wb_data, 99);
    step(); #1;
    // unit never answers -> timeout at counter 48
    issue(1'b1, 5'd6, 32'd1, 32'd1);
    quiet(48, "to_wait_quiet");
    step(); #1;
    chk("to_pulse", 32'(timeout_err), 1);
    chk("to_pulse_wb", 32'(wb_valid), 0);
    step(); #1;
    chk("to_after_pulse", 32'(timeout_err), 0);
    chk("to_after_ready", 32'(issue_ready), 1);
    chk("to_after_wb", 32'(wb_valid), 0);
    // reset mid-WAIT
    issue(1'b0, 5'd8, 32'd11, 32'd13);
    quiet(3, "rst_wait_quiet");
    step(); clrn = 1'b0; #1;
    step(); clrn = 1'b1; #1;
    reset_vals("midrst");
    // RDY and flush collide in WAIT
    issue(1'b0, 5'd10, 32'd2, 32'd3);
    quiet(4, "coll_wait_quiet");
    step(); data_resultRDY = 1'b1; flush = 1'b1; data_result = 32'd5; #1;
    step(); data_resultRDY = 1'b0; flush = 1'b0; #1;
    chk("coll_stall", 32'(stall), 0);
    chk("coll_wb", 32'(wb_valid), 0);
    chk("coll_ready", 32'(issue_ready), 1);
    step(); #1;
    chk("coll_wb_next", 32'(wb_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
